// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and the data RAM. Misaligned halfword
// and word accesses become two aligned beats; loads return extended on a response pulse.
module load_store_unit #(
   parameter int address_size = 32,
   parameter int word_size    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [2:0]              req_funct3,
   input  logic [address_size-1:0] req_addr,
   input  logic [word_size-1:0]    req_wdata,
   output logic                    resp_valid,
   output logic                    resp_err,
   output logic [word_size-1:0]    resp_rdata,
   output logic [address_size-1:0] dmem_addr,
   inout  wire  [word_size-1:0]    dmem_data,
   output logic                    dmem_wen,
   output logic                    read,
   output logic [3:0]              byte_en
);

   // state | meaning
   // IDLE  | waiting for a request
   // BEAT0 | first (or only) aligned RAM access
   // BEAT1 | second aligned access of a split request
   // RESP  | response pulse; a new request may be accepted here
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [1:0]              off_q, off_d;
   logic [3:0]              mask_q, mask_d;
   logic                    split_q, split_d;
   logic [word_size-1:0]    wdata_q, wdata_d;
   logic [word_size-1:0]    acc_q, acc_d;
   logic                    resp_err_q, resp_err_d;
   logic [word_size-1:0]    resp_rdata_q, resp_rdata_d;
   logic [address_size-1:0] dmem_addr_q, dmem_addr_d;

   logic                    accept;
   logic                    req_illegal;
   logic [3:0]              req_mask;
   logic [3:0]              req_size;
   logic                    req_split;
   logic [4:0]              sh_lo;
   logic [5:0]              sh_hi;
   logic [7:0]              lane_wide;
   logic [2*word_size-1:0]  st_wide;
   logic [word_size-1:0]    rd_lo;
   logic [word_size-1:0]    rd_merged;
   logic [word_size-1:0]    wdata_out;
   logic                    in_beat;

   function automatic logic [word_size-1:0] extend_load(input logic [2:0] f3,
                                                        input logic [word_size-1:0] v);
      logic [word_size-1:0] r;
      case (f3[1:0])
         2'b00:   r = {{(word_size-8){~f3[2] & v[7]}}, v[7:0]};
         2'b01:   r = {{(word_size-16){~f3[2] & v[15]}}, v[15:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   assign req_ready  = (state_q == IDLE) || (state_q == RESP);
   assign accept     = req_valid & req_ready;
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign dmem_addr  = dmem_addr_q;

   always_comb begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
      case (req_funct3[1:0])
         2'b00: begin
            req_mask = 4'b0001;
            req_size = 4'd1;
         end
         2'b01: begin
            req_mask = 4'b0011;
            req_size = 4'd2;
         end
         default: begin
            req_mask = 4'b1111;
            req_size = 4'd4;
         end
      endcase
      req_split = ({2'b00, req_addr[1:0]} + req_size) > 4'd4;
   end

   // Lanes and data are shifted into an 8-lane / 64-bit window: the low half
   // feeds BEAT0 and whatever spills into the high half feeds BEAT1.
   assign sh_lo     = {off_q, 3'b000};
   assign sh_hi     = 6'd32 - {1'b0, sh_lo};
   assign lane_wide = {4'b0000, mask_q} << off_q;
   assign st_wide   = {{word_size{1'b0}}, wdata_q} << sh_lo;
   assign rd_lo     = dmem_data >> sh_lo;
   assign rd_merged = acc_q | (dmem_data << sh_hi);

   assign in_beat   = (state_q == BEAT0) || (state_q == BEAT1);
   assign dmem_wen  = in_beat & we_q;
   assign read      = in_beat & ~we_q;
   assign wdata_out = (state_q == BEAT1) ? st_wide[2*word_size-1:word_size]
                                         : st_wide[word_size-1:0];
   assign dmem_data = dmem_wen ? wdata_out : {word_size{1'bz}};

   always_comb begin
      case (state_q)
         BEAT0:   byte_en = lane_wide[3:0];
         BEAT1:   byte_en = lane_wide[7:4];
         default: byte_en = 4'b0000;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      mask_d       = mask_q;
      split_d      = split_q;
      wdata_d      = wdata_q;
      acc_d        = acc_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      dmem_addr_d  = dmem_addr_q;
      case (state_q)
         IDLE, RESP: begin
            if (accept) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               off_d    = req_addr[1:0];
               mask_d   = req_mask;
               split_d  = req_split;
               wdata_d  = req_wdata;
               acc_d    = '0;
               if (req_illegal) begin
                  state_d      = RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d     = BEAT0;
                  dmem_addr_d = {req_addr[address_size-1:2], 2'b00};
               end
            end else begin
               state_d = IDLE;
            end
         end
         BEAT0: begin
            if (!we_q) begin
               acc_d = rd_lo;
            end
            if (split_q) begin
               state_d     = BEAT1;
               dmem_addr_d = dmem_addr_q + address_size'(4);
            end else begin
               state_d      = RESP;
               resp_err_d   = 1'b0;
               resp_rdata_d = we_q ? '0 : extend_load(funct3_q, rd_lo);
            end
         end
         BEAT1: begin
            state_d      = RESP;
            resp_err_d   = 1'b0;
            resp_rdata_d = we_q ? '0 : extend_load(funct3_q, rd_merged);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         mask_q       <= 4'b0000;
         split_q      <= 1'b0;
         wdata_q      <= '0;
         acc_q        <= '0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         dmem_addr_q  <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         mask_q       <= mask_d;
         split_q      <= split_d;
         wdata_q      <= wdata_d;
         acc_q        <= acc_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         dmem_addr_q  <= dmem_addr_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array RAM on the bus, byte-level reference
// memory model, directed cases followed by randomized traffic.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] dmem_addr;
   wire  [31:0] dmem_data;
   logic        dmem_wen;
   logic        read;
   logic [3:0]  byte_en;

   logic [7:0]  ram   [0:4095];
   logic [7:0]  ref_b [0:4095];
   logic [31:0] ram_rd;
   logic        init_req;

   int errors = 0;
   int checks = 0;

   logic [31:0] ob_addr [0:3];
   logic [31:0] ob_data [0:3];
   logic [3:0]  ob_be   [0:3];
   logic        ob_wen  [0:3];
   logic        ob_rd   [0:3];
   logic        any_rd, any_wr;
   int          lat_obs;

   load_store_unit #(.address_size(32), .word_size(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .dmem_addr(dmem_addr), .dmem_data(dmem_data),
      .dmem_wen(dmem_wen), .read(read), .byte_en(byte_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37) ^ (i >> 3) ^ 32'h5A);
   endfunction

   always_comb begin
      ram_rd = {ram[dmem_addr[11:0] + 12'd3], ram[dmem_addr[11:0] + 12'd2],
                ram[dmem_addr[11:0] + 12'd1], ram[dmem_addr[11:0]]};
   end
   assign dmem_data = read ? ram_rd : 32'bz;

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
      end else if (dmem_wen) begin
         for (int i = 0; i < 4; i++)
            if (byte_en[i]) ram[dmem_addr[11:0] + 12'(i)] <= dmem_data[8*i +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: an access is just a little-endian byte read/write of size bytes.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
      int size;
      int idx;
      logic [31:0] v;
      er = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      rd = 32'h0;
      lat = 0;
      v = 32'h0;
      if (!er) begin
         lat = (int'(a[1:0]) + size > 4) ? 2 : 1;
         for (int i = 0; i < size; i++) begin
            idx = int'((a + 32'(i)) & 32'hFFF);
            if (we) ref_b[idx] = wd[8*i +: 8];
            else    v[8*i +: 8] = ref_b[idx];
         end
         if (!we) begin
            if (size == 1)      rd = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            else if (size == 2) rd = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            else                rd = v;
         end
      end
   endtask

   task automatic access(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd_out);
      logic [31:0] exp_rd;
      logic        exp_er;
      int          exp_lat;
      int          guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat_obs = 0; any_rd = 1'b0; any_wr = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            ob_addr[k] = dmem_addr; ob_data[k] = dmem_data; ob_be[k] = byte_en;
            ob_wen[k] = dmem_wen; ob_rd[k] = read;
         end
         any_rd |= read;
         any_wr |= dmem_wen;
         if (resp_valid) break;
         @(posedge clk);
         #1;
         lat_obs++;
      end
      rd_out = resp_rdata;
      model(we, f3, a, wd, exp_rd, exp_er, exp_lat);
      check({tag, "_lat"}, 32'(lat_obs), 32'(exp_lat));
      check({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_er});
      check({tag, "_rdata"}, resp_rdata, exp_rd);
   endtask

   logic [31:0] rd;
   logic        saw_resp;
   int          mm;

   initial begin
      rst_n = 1'b0; init_req = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < 4096; i++) ref_b[i] = init_byte(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      init_req = 1'b0;
      check("rst_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_err", {31'h0, resp_err}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_addr", dmem_addr, 32'h0);
      check("rst_wen_read_be", {26'h0, dmem_wen, read, byte_en}, 32'h0);
      rst_n = 1'b1;

      access("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd);
      check("sw100_b0_addr", ob_addr[0], 32'h100);
      check("sw100_b0_be", {28'h0, ob_be[0]}, 32'hF);
      check("sw100_b0_wen", {31'h0, ob_wen[0]}, 32'h1);
      check("sw100_b0_data", ob_data[0], 32'hDEADBEEF);

      access("sw80", 1'b1, 3'b010, 32'h100, 32'h80000000, rd);
      access("lb103", 1'b0, 3'b000, 32'h103, 32'h0, rd);
      check("lb103_const", rd, 32'hFFFFFF80);
      access("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, rd);
      check("lbu103_const", rd, 32'h00000080);
      access("lh102", 1'b0, 3'b001, 32'h102, 32'h0, rd);
      check("lh102_const", rd, 32'hFFFF8000);

      access("sh203", 1'b1, 3'b001, 32'h203, 32'h00001234, rd);
      check("sh203_b0_addr", ob_addr[0], 32'h200);
      check("sh203_b0_be", {28'h0, ob_be[0]}, 32'h8);
      check("sh203_b0_data", ob_data[0], 32'h34000000);
      check("sh203_b1_addr", ob_addr[1], 32'h204);
      check("sh203_b1_be", {28'h0, ob_be[1]}, 32'h1);
      check("sh203_b1_data", ob_data[1], 32'h00000012);
      check("sh203_hold_addr", ob_addr[2], 32'h204);
      check("sh203_resp_be", {28'h0, ob_be[2]}, 32'h0);

      access("sw100b", 1'b1, 3'b010, 32'h100, 32'h44332211, rd);
      access("sw104", 1'b1, 3'b010, 32'h104, 32'h88776655, rd);
      access("lw101", 1'b0, 3'b010, 32'h101, 32'h0, rd);
      check("lw101_const", rd, 32'h55443322);
      check("lw101_reads", {30'h0, ob_rd[0], ob_rd[1]}, 32'h3);

      access("ill011", 1'b0, 3'b011, 32'h300, 32'h0, rd);
      check("ill011_noaccess", {30'h0, any_rd, any_wr}, 32'h0);

      access("swwrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, rd);
      check("swwrap_b0_addr", ob_addr[0], 32'hFFFFFFFC);
      check("swwrap_b1_addr", ob_addr[1], 32'h00000000);

      // Reset in the middle of a split store's second beat.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h1FE; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rst_b0_be", {28'h0, byte_en}, 32'hC);
      check("rst_b0_data", dmem_data, 32'hF00D0000);
      @(posedge clk);
      #1;
      check("rst_b1_wen", {31'h0, dmem_wen}, 32'h1);
      check("rst_b1_addr", dmem_addr, 32'h200);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_wen", {31'h0, dmem_wen}, 32'h0);
      check("rst_mid_be", {28'h0, byte_en}, 32'h0);
      check("rst_mid_addr", dmem_addr, 32'h0);
      check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
      saw_resp = resp_valid;
      repeat (2) begin
         @(posedge clk);
         #1;
         saw_resp |= resp_valid;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         saw_resp |= resp_valid;
      end
      check("rst_no_resp", {31'h0, saw_resp}, 32'h0);
      check("rst_after_ready", {31'h0, req_ready}, 32'h1);
      ref_b[12'h1FE] = 8'h0D;
      ref_b[12'h1FF] = 8'hF0;
      access("lw1fc", 1'b0, 3'b010, 32'h1FC, 32'h0, rd);

      for (int n = 0; n < 120; n++) begin
         logic [31:0] ra;
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra = 32'h300 + 32'($urandom_range(0, 63));
         access("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, rd);
      end

      @(negedge clk);
      mm = 0;
      for (int i = 0; i < 4096; i++) if (ram[i] !== ref_b[i]) mm++;
      check("mem_final_diffs", 32'(mm), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the CPU execute stage and the data RAM. It accepts one load or store request per handshake and drives the RAM's address, byte-enable, write-enable and shared bidirectional data bus. Misaligned halfword and word accesses are split into two aligned beats. Load results return sign- or zero-extended on a single-cycle response pulse.

## Interface
- address_size, 32, width of request and RAM address
- word_size, 32, data width; fixed at 32, other values unsupported

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; handshake = req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  address_size  byte address
- req_wdata  in  word_size  store data, LSB-aligned
- resp_valid  out  1  one-cycle response pulse, no back-pressure
- resp_err  out  1  illegal funct3; valid with resp_valid
- resp_rdata  out  word_size  extended load data; 0 for stores and errors
- dmem_addr  out  address_size  word-aligned RAM address (bits [1:0] always 0)
- dmem_data  inout  word_size  driven only while dmem_wen=1, else high-Z
- dmem_wen  out  1  RAM write enable
- read  out  1  high during load beats
- byte_en  out  4  per-byte lane enables

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- req_ready = 1 in IDLE and RESP, 0 in BEAT0/BEAT1. Accepting a request in RESP is legal and goes straight to BEAT0.
- On accept, the unit registers the request and computes:
  - off = addr[1:0]
  - mask = 0001 for B, 0011 for H, 1111 for W
  - split = (off + size_bytes > 4), i.e. H at off 3 or W at off 1–3
- Illegal request: funct3 ∈ {011, 110, 111}, or a store with funct3[2]=1.
  - Next state RESP with resp_err=1; no RAM access.
- BEAT0 outputs:
  - dmem_addr = {addr[31:2], 00}
  - byte_en = (mask << off)[3:0]
  - store data = wdata << 8·off
- BEAT1 outputs (split only):
  - dmem_addr = BEAT0 address + 4, wraps modulo 2^address_size
  - byte_en = mask >> (4 − off)
  - store data = wdata >> 8·(4 − off)
- Loads:
  - BEAT0 captures dmem_data >> 8·off.
  - BEAT1 ORs in dmem_data << 8·(4 − off).
  - Result masked to size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
- The RAM read is combinational. It is sampled at the rising edge ending each load beat.
- Transitions:
  - IDLE/RESP → BEAT0 on legal accept, → RESP on illegal accept, otherwise IDLE.
  - BEAT0 → BEAT1 if split, else RESP.
  - BEAT1 → RESP.
- Outside BEAT0/BEAT1: dmem_wen=0, read=0, byte_en=0000, dmem_data high-Z, dmem_addr holds its last value.

## Timing
- Reset values:
  - state IDLE
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0
  - dmem_addr=0, dmem_wen=0, read=0, byte_en=0000, dmem_data high-Z
- Accept at edge T:
  - aligned access: BEAT0 in cycle T+1, resp_valid in cycle T+2
  - split access: BEAT1 in cycle T+2, resp_valid in cycle T+3
  - illegal access: resp_valid in cycle T+1
- Store write commits at the rising edge ending each beat.
- Back-to-back aligned accesses sustain one access per 2 cycles.
- resp_rdata/resp_err are valid only while resp_valid=1 and hold until the next response.
- rst_n low mid-access:
  - outputs return to reset values immediately
  - pending response is dropped
  - a split store whose BEAT0 already committed is not rolled back

## Test plan
- SW addr 0x100, data 0xDEADBEEF → BEAT0: dmem_addr 0x100, byte_en 1111, dmem_wen 1, dmem_data 0xDEADBEEF. resp_valid at T+2 with resp_err 0.
- Word 0x80000000 at 0x100: LB 0x103 → resp_rdata 0xFFFFFF80. LBU 0x103 → 0x00000080. LH 0x102 → 0xFFFF8000.
- SH addr 0x203, data 0x00001234 → BEAT0: addr 0x200, byte_en 1000, data 0x34000000. BEAT1: addr 0x204, byte_en 0001, data 0x00000012. resp_valid at T+3.
- mem[0x100]=0x44332211, mem[0x104]=0x88776655, LW 0x101 → two read beats, resp_rdata 0x55443322 at T+3.
- Load with funct3=011 → resp_valid at T+1 with resp_err 1, resp_rdata 0. read and dmem_wen never asserted.
- Split SW at 0x1FE with rst_n low during BEAT1 → dmem_wen drops without waiting for clk, no resp_valid. After release, req_ready=1 and a following LW 0x1FC completes normally.
